fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 18 +
 rtl/branch_lut.sv | 18 +
 rtl/fetch_ctrl.sv | 96 +++++++++
 tb/tb_fetch_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller: FSM states, default pc width
// and the branch target table.
package fetch_pkg;

  localparam int unsigned PcBitsDefault = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fetch_state_e;

  // Absolute branch targets; widths are truncated to PC_BITS at the lookup.
  localparam logic [31:0] BranchTargets [8] = '{
    32'd0, 32'd100, 32'd40, 32'd10, 32'd4093, 32'd30, 32'd20, 32'd7
  };

endpackage

// File: rtl/branch_lut.sv
// Read-only combinational branch target lookup over the fetch_pkg table.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int unsigned PC_BITS = PcBitsDefault
) (
  input  logic [2:0]         idx,
  output logic [PC_BITS-1:0] target
);

  logic [31:0] entry;

  always_comb begin
    entry  = BranchTargets[idx];
    target = entry[PC_BITS-1:0];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Program fetch controller: IDLE/RUN/DONE sequencer producing the instruction fetch
// address, with branch targets from a fixed lookup table and a retired-instruction count.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned PC_BITS  = PcBitsDefault,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic                stall,
  input  logic                jump,
  input  logic                branch_taken,
  input  logic [2:0]          target_idx,
  output logic [PC_BITS-1:0]  pc,
  output logic                running,
  output logic                done,
  output logic [CNT_BITS-1:0] instr_count
);

  fetch_state_e        state_q;
  logic [PC_BITS-1:0]  pc_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                running_q;
  logic                done_q;
  logic [PC_BITS-1:0]  lut_target;
  logic [CNT_BITS-1:0] cnt_inc;

  branch_lut #(
    .PC_BITS(PC_BITS)
  ) u_branch_lut (
    .idx   (target_idx),
    .target(lut_target)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StRun;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        StRun: begin
          // Halt outranks stall, so the halt cycle always retires.
          if (halt_req || !stall) begin
            cnt_q <= cnt_inc;
          end
          if (halt_req) begin
            state_q   <= StDone;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (!stall) begin
            if (jump || branch_taken) begin
              pc_q <= lut_target;
            end else if (pc_q == '1) begin
              // Running off the end of memory finishes the program instead of wrapping.
              state_q   <= StDone;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          pc_q      <= '0;
          cnt_q     <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hand-computed pc/count/status after each clock edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, halt_req, stall, jump, branch_taken;
  logic [2:0]  target_idx;
  logic [11:0] pc;
  logic        running, done;
  logic [15:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_ctrl #(
    .PC_BITS (12),
    .CNT_BITS(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .stall       (stall),
    .jump        (jump),
    .branch_taken(branch_taken),
    .target_idx  (target_idx),
    .pc          (pc),
    .running     (running),
    .done        (done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_pc, input int e_cnt,
                         input logic e_run, input logic e_done);
    chk({tag, " pc"}, 32'(pc), 32'(e_pc));
    chk({tag, " count"}, 32'(instr_count), 32'(e_cnt));
    chk({tag, " running"}, 32'(running), 32'(e_run));
    chk({tag, " done"}, 32'(done), 32'(e_done));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; stall = 1'b0;
    jump = 1'b0; branch_taken = 1'b0; target_idx = 3'd0;
    tick(); tick();
    chk_all("reset", 0, 0, 1'b0, 1'b0);

    // Control inputs are ignored in IDLE.
    reset = 1'b0; jump = 1'b1; halt_req = 1'b1; target_idx = 3'd2;
    tick();
    chk_all("idle ignore", 0, 0, 1'b0, 1'b0);
    jump = 1'b0; halt_req = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("start", 0, 0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("seq pc%0d", i), 32'(pc), 32'(i));
    end
    chk_all("seq end", 5, 5, 1'b1, 1'b0);

    tick(); tick();
    chk_all("at 7", 7, 7, 1'b1, 1'b0);
    jump = 1'b1; target_idx = 3'd2;
    tick();
    jump = 1'b0;
    chk_all("jump 40", 40, 8, 1'b1, 1'b0);
    tick();
    chk_all("after jump", 41, 9, 1'b1, 1'b0);

    branch_taken = 1'b1; target_idx = 3'd3;
    tick();
    branch_taken = 1'b0;
    chk_all("branch 10", 10, 10, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("stall%0d", i), 10, 10, 1'b1, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk_all("unstall", 11, 11, 1'b1, 1'b0);

    branch_taken = 1'b1; target_idx = 3'd6;
    tick();
    chk_all("branch 20", 20, 12, 1'b1, 1'b0);
    halt_req = 1'b1; target_idx = 3'd1;
    tick();
    halt_req = 1'b0; branch_taken = 1'b0;
    chk_all("halt", 20, 13, 1'b0, 1'b1);
    jump = 1'b1; stall = 1'b1;
    tick();
    jump = 1'b0; stall = 1'b0;
    chk_all("done hold", 20, 13, 1'b0, 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart", 0, 0, 1'b1, 1'b0);
    tick();
    jump = 1'b1; target_idx = 3'd0;
    tick();
    jump = 1'b0;
    chk_all("jump to 0", 0, 2, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("start in run", 1, 3, 1'b1, 1'b0);

    jump = 1'b1; target_idx = 3'd4;
    tick();
    jump = 1'b0;
    chk_all("jump 4093", 4093, 4, 1'b1, 1'b0);
    tick(); tick();
    chk_all("at 4095", 4095, 6, 1'b1, 1'b0);
    tick();
    chk_all("end of mem", 4095, 7, 1'b0, 1'b1);
    tick();
    chk_all("end hold", 4095, 7, 1'b0, 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    jump = 1'b1; target_idx = 3'd5;
    tick();
    jump = 1'b0;
    tick(); tick(); tick();
    chk_all("at 33", 33, 4, 1'b1, 1'b0);
    reset = 1'b1; start = 1'b1;
    tick();
    chk_all("mid-run reset", 0, 0, 1'b0, 1'b0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk_all("post reset idle", 0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
